fft_output_streamer: RTL and testbench

Back end of the 32-point FFT pipeline, downstream of the last butterfly stage. It captures all 32 complex results in one cycle when the last stage signals finish. It then streams them out one complex word per cycle over a valid/ready interface, in natural frequency order. It also flags a frame marker, a completion pulse and overflow of a frame arriving while one is still streaming.

---
 rtl/fft_output_streamer.sv | 109 ++++++++++
 tb/tb_fft_output_streamer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_streamer.sv
// Output stage of the 32-point FFT: snapshots one complete frame from the last butterfly stage
// and streams it out one complex word per beat over valid/ready, in frequency order.
module fft_output_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int INTEGER     = 4,
    parameter int FRACTION    = 4,
    parameter int BIT_REVERSE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture_start,
    input  logic [32*DATA_WIDTH-1:0] in_real_flat,
    input  logic [32*DATA_WIDTH-1:0] in_imag_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_real,
    output logic [DATA_WIDTH-1:0]    out_imag,
    output logic [4:0]               out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overflow
);

    // The Q-format is only carried for documentation of the data; it must describe the word.
    if (INTEGER + FRACTION != DATA_WIDTH) begin : g_fmt_check
        $error("INTEGER + FRACTION must equal DATA_WIDTH");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] k;
    logic       xfer;
    logic       final_xfer;
    logic       capture_en;
    logic [4:0] rd_idx;

    logic signed [DATA_WIDTH-1:0] buf_real_p0 [32];
    logic signed [DATA_WIDTH-1:0] buf_imag_p0 [32];

    function automatic logic [4:0] bitrev5(input logic [4:0] idx);
        bitrev5 = {idx[0], idx[1], idx[2], idx[3], idx[4]};
    endfunction

    assign xfer       = (state == STREAM) && out_ready;
    assign final_xfer = xfer && (k == 5'd31);
    // A frame is accepted when idle, or exactly as the previous frame's last beat leaves.
    assign capture_en = capture_start && ((state == IDLE) || final_xfer);
    assign rd_idx     = (BIT_REVERSE != 0) ? bitrev5(k) : k;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= 5'd0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= final_xfer;
            case (state)
                IDLE: begin
                    k <= 5'd0;
                    if (capture_start) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (k == 5'd31) begin
                            k     <= 5'd0;
                            state <= capture_start ? STREAM : IDLE;
                        end else begin
                            k <= k + 5'd1;
                        end
                    end
                    if (capture_start && !final_xfer) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    k     <= 5'd0;
                end
            endcase
        end
    end

    // Stage p0: frame snapshot, held until the next accepted capture
    always_ff @(posedge clk) begin
        if (capture_en) begin
            for (int i = 0; i < 32; i++) begin
                buf_real_p0[i] <= in_real_flat[i*DATA_WIDTH +: DATA_WIDTH];
                buf_imag_p0[i] <= in_imag_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output read port: words leave bit-exact; idle outputs read zero
    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_index = k;
    assign out_last  = (state == STREAM) && (k == 5'd31);
    assign out_real  = (state == STREAM) ? $unsigned(buf_real_p0[rd_idx]) : '0;
    assign out_imag  = (state == STREAM) ? $unsigned(buf_imag_p0[rd_idx]) : '0;

endmodule

// File: tb/tb_fft_output_streamer.sv
// Bench for fft_output_streamer: bit-reversed and natural-order instances share one input frame;
// expected beats are queued at capture time and popped on every transfer.
module tb_fft_output_streamer;

    logic              clk = 1'b0;
    logic              reset;
    logic              capture_start;
    logic              out_ready;
    logic [32*8-1:0]   in_real_flat;
    logic [32*8-1:0]   in_imag_flat;

    logic       out_valid, out_last, busy, frame_done, overflow;
    logic [7:0] out_real, out_imag;
    logic [4:0] out_index;
    logic       n_out_valid, n_out_last, n_busy, n_frame_done, n_overflow;
    logic [7:0] n_out_real, n_out_imag;
    logic [4:0] n_out_index;

    typedef struct packed {
        logic [7:0] re;
        logic [7:0] im;
        logic [4:0] idx;
        logic       last;
    } beat_t;

    beat_t      sb[$];
    beat_t      sb_nat[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fr_re [32];
    logic [7:0] fr_im [32];
    logic       xfer;

    fft_output_streamer #(.DATA_WIDTH(8), .INTEGER(4), .FRACTION(4), .BIT_REVERSE(1)) u_dut_br (
        .clk(clk), .reset(reset), .capture_start(capture_start),
        .in_real_flat(in_real_flat), .in_imag_flat(in_imag_flat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
        .out_last(out_last), .busy(busy), .frame_done(frame_done), .overflow(overflow)
    );

    fft_output_streamer #(.DATA_WIDTH(8), .INTEGER(4), .FRACTION(4), .BIT_REVERSE(0)) u_dut_nat (
        .clk(clk), .reset(reset), .capture_start(capture_start),
        .in_real_flat(in_real_flat), .in_imag_flat(in_imag_flat),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_real(n_out_real), .out_imag(n_out_imag), .out_index(n_out_index),
        .out_last(n_out_last), .busy(n_busy), .frame_done(n_frame_done), .overflow(n_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] bitrev(input logic [4:0] v);
        logic [4:0] r;
        for (int b = 0; b < 5; b++) r[4-b] = v[b];
        return r;
    endfunction

    // mode 0: re=i im=-i; mode 1: re=i+32 im=-(i+32); mode 2: all 0x7F
    task automatic set_frame(input int mode);
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0:       begin fr_re[i] = 8'(i);      fr_im[i] = 8'(-i);        end
                1:       begin fr_re[i] = 8'(i + 32); fr_im[i] = 8'(-(i + 32)); end
                default: begin fr_re[i] = 8'h7F;      fr_im[i] = 8'h7F;         end
            endcase
            in_real_flat[i*8 +: 8] = fr_re[i];
            in_imag_flat[i*8 +: 8] = fr_im[i];
        end
    endtask

    task automatic push_frame(input bit br);
        beat_t e;
        for (int kk = 0; kk < 32; kk++) begin
            e.idx  = 5'(kk);
            e.last = (kk == 31);
            e.re   = br ? fr_re[bitrev(5'(kk))] : fr_re[kk];
            e.im   = br ? fr_im[bitrev(5'(kk))] : fr_im[kk];
            if (br) sb.push_back(e);
            else    sb_nat.push_back(e);
        end
    endtask

    task automatic step(input logic rdy, input logic cap, input logic rst);
        @(negedge clk);
        out_ready     = rdy;
        capture_start = cap;
        reset         = rst;
        #1;
        xfer = out_valid && out_ready && !rst;
    endtask

    task automatic test_reset();
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 0);
        n_checks++;
        if ({out_valid, out_last, busy, frame_done, overflow, out_real, out_imag, out_index} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h required 0",
                     {out_valid, out_last, busy, frame_done, overflow, out_real, out_imag, out_index});
        end
        step(1, 0, 0);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_ready: valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic();
        beat_t exp_b, obs;
        set_frame(0);
        push_frame(1);
        step(1, 1, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pre_valid: got %b required 0", out_valid);
        end
        for (int c = 0; c < 32; c++) begin
            step(1, 0, 0);
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL basic_valid beat %0d: valid=%b busy=%b required 1 1", c, out_valid, busy);
            end else begin
                exp_b = sb.pop_front();
                obs   = {out_real, out_imag, out_index, out_last};
                n_checks++;
                if (obs !== exp_b) begin
                    n_fail++;
                    $display("FAIL basic_beat %0d: got %h required %h", c, obs, exp_b);
                end
            end
        end
        step(1, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b busy=%b valid=%b required 1 0 0", frame_done, busy, out_valid);
        end
        step(1, 0, 0);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %b required 0", frame_done);
        end
    endtask

    task automatic test_natural();
        beat_t exp_b, obs;
        set_frame(0);
        push_frame(0);
        step(1, 1, 0);
        for (int c = 0; c < 32; c++) begin
            step(1, 0, 0);
            n_checks++;
            if (n_out_valid !== 1'b1 || sb_nat.size() == 0) begin
                n_fail++;
                $display("FAIL natural_valid beat %0d: got %b required 1", c, n_out_valid);
            end else begin
                exp_b = sb_nat.pop_front();
                obs   = {n_out_real, n_out_imag, n_out_index, n_out_last};
                n_checks++;
                if (obs !== exp_b) begin
                    n_fail++;
                    $display("FAIL natural_beat %0d: got %h required %h", c, obs, exp_b);
                end
            end
        end
        step(1, 0, 0);
        n_checks++;
        if (n_frame_done !== 1'b1 || n_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL natural_done: done=%b valid=%b required 1 0", n_frame_done, n_out_valid);
        end
    endtask

    task automatic test_backpressure();
        beat_t exp_b, obs;
        int    c;
        int    transfers;
        logic  rdy;
        set_frame(0);
        push_frame(1);
        step(1, 1, 0);
        c = 0;
        transfers = 0;
        while (transfers < 32 && c < 200) begin
            if (c < 3)       rdy = 1'b1;
            else if (c <= 6) rdy = 1'b0;
            else             rdy = ((c - 7) % 2 == 0);
            step(rdy, 0, 0);
            obs = {out_real, out_imag, out_index, out_last};
            n_checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL bp_valid cycle %0d: got %b required 1", c, out_valid);
            end else if (xfer) begin
                exp_b = sb.pop_front();
                transfers++;
                if (obs !== exp_b) begin
                    n_fail++;
                    $display("FAIL bp_beat %0d: got %h required %h", transfers - 1, obs, exp_b);
                end
            end else begin
                if (obs !== sb[0]) begin
                    n_fail++;
                    $display("FAIL bp_hold cycle %0d: got %h required %h", c, obs, sb[0]);
                end
                if (c == 3) begin
                    n_checks++;
                    if (out_real !== 8'd24) begin
                        n_fail++;
                        $display("FAIL bp_beat3_real: got %0d required 24", out_real);
                    end
                end
            end
            c++;
        end
        n_checks++;
        if (transfers != 32 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d transfers (%0d left) required 32 (0 left)", transfers, sb.size());
        end
        step(1, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: done=%b valid=%b required 1 0", frame_done, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        beat_t exp_b, obs;
        int    fd_count;
        set_frame(0);
        push_frame(1);
        step(1, 1, 0);
        fd_count = 0;
        for (int c = 0; c < 64; c++) begin
            if (c == 31) begin
                set_frame(1);
                push_frame(1);
            end
            step(1, (c == 31), 0);
            if (frame_done === 1'b1) fd_count++;
            obs = {out_real, out_imag, out_index, out_last};
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_valid beat %0d: valid=%b busy=%b required 1 1", c, out_valid, busy);
            end else begin
                exp_b = sb.pop_front();
                if (obs !== exp_b) begin
                    n_fail++;
                    $display("FAIL b2b_beat %0d: got %h required %h", c, obs, exp_b);
                end
            end
            if (c == 32) begin
                n_checks++;
                if (frame_done !== 1'b1 || out_real !== 8'd32) begin
                    n_fail++;
                    $display("FAIL b2b_seam: done=%b real=%0d required 1 32", frame_done, out_real);
                end
            end
        end
        step(1, 0, 0);
        if (frame_done === 1'b1) fd_count++;
        n_checks++;
        if (fd_count != 2 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: done pulses=%0d overflow=%b busy=%b required 2 0 0", fd_count, overflow, busy);
        end
    endtask

    task automatic test_overflow();
        beat_t exp_b, obs;
        set_frame(0);
        push_frame(1);
        step(1, 1, 0);
        for (int c = 0; c < 32; c++) begin
            if (c == 10) set_frame(2);
            step(1, (c == 10), 0);
            obs = {out_real, out_imag, out_index, out_last};
            n_checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL ovf_valid beat %0d: got %b required 1", c, out_valid);
            end else begin
                exp_b = sb.pop_front();
                if (obs !== exp_b) begin
                    n_fail++;
                    $display("FAIL ovf_beat %0d: got %h required %h", c, obs, exp_b);
                end
            end
            n_checks++;
            if (overflow !== (c > 10)) begin
                n_fail++;
                $display("FAIL ovf_flag beat %0d: got %b required %b", c, overflow, (c > 10));
            end
        end
        step(1, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_done: done=%b overflow=%b required 1 1", frame_done, overflow);
        end
        step(1, 0, 0);
        n_checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_sticky: overflow=%b valid=%b required 1 0", overflow, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        beat_t exp_b, obs;
        set_frame(0);
        push_frame(1);
        step(1, 1, 0);
        for (int c = 0; c < 12; c++) begin
            step(1, 0, 0);
            obs = {out_real, out_imag, out_index, out_last};
            n_checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL rst_pre_valid beat %0d: got %b required 1", c, out_valid);
            end else begin
                exp_b = sb.pop_front();
                if (obs !== exp_b) begin
                    n_fail++;
                    $display("FAIL rst_pre_beat %0d: got %h required %h", c, obs, exp_b);
                end
            end
        end
        step(1, 0, 1);
        step(0, 0, 0);
        n_checks++;
        if ({out_valid, out_last, busy, frame_done, overflow, out_real, out_imag, out_index} !== 29'd0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got %h required 0",
                     {out_valid, out_last, busy, frame_done, overflow, out_real, out_imag, out_index});
        end
        sb.delete();
        set_frame(1);
        push_frame(1);
        step(1, 1, 0);
        for (int c = 0; c < 32; c++) begin
            step(1, 0, 0);
            obs = {out_real, out_imag, out_index, out_last};
            n_checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL rst_post_valid beat %0d: got %b required 1", c, out_valid);
            end else begin
                exp_b = sb.pop_front();
                if (obs !== exp_b) begin
                    n_fail++;
                    $display("FAIL rst_post_beat %0d: got %h required %h", c, obs, exp_b);
                end
            end
        end
        step(1, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_post_done: done=%b overflow=%b busy=%b required 1 0 0", frame_done, overflow, busy);
        end
    endtask

    initial begin
        reset         = 1'b1;
        capture_start = 1'b0;
        out_ready     = 1'b0;
        in_real_flat  = '0;
        in_imag_flat  = '0;
        xfer          = 1'b0;
        test_reset();
        test_basic();
        test_natural();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
